cp0_unit: RTL and testbench

//  Coprocessor-0 register file and exception controller; sits in the M stage and consumes
//  the 5-bit M_ExcCode produced by the exception encoder. Holds SR/Cause/EPC/PRId, decides

---
 rtl/cp0_unit_pkg.sv | 54 +++++
 rtl/cp0_unit_if.sv | 26 ++
 rtl/cp0_unit.sv | 119 +++++++++++
 tb/tb_cp0_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, bit positions, exception codes and word packers.
// Used by the CP0 unit, the exception encoder and the control decoder.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned SR_IE_BIT     = 0;
    localparam int unsigned SR_EXL_BIT    = 1;
    localparam int unsigned SR_IM_LSB     = 10;
    localparam int unsigned SR_IM_MSB     = 15;
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_EXC_MSB = 6;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_IP_MSB  = 15;
    localparam int unsigned CAUSE_BD_BIT  = 31;

    localparam logic [4:0] EXC_NONE    = 5'd0;
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] PRID_DEFAULT         = 32'h0000_7F7F;
    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;

    // EXL is the handler-mode flag; unimplemented bits read as zero.
    typedef enum logic {StNormal = 1'b0, StHandler = 1'b1} exl_state_e;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                            input logic ie);
        logic [31:0] w;
        w = '0;
        w[SR_IM_MSB:SR_IM_LSB] = im;
        w[SR_EXL_BIT] = exl;
        w[SR_IE_BIT] = ie;
        return w;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                               input logic [4:0] exc);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD_BIT] = bd;
        w[CAUSE_IP_MSB:CAUSE_IP_LSB] = ip;
        w[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline <-> CP0 connection: mfc0/mtc0 access, M-stage exception info and redirect outputs.
interface cp0_unit_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] Din;
    logic        we;
    logic [31:0] M_pc;
    logic        M_bd;
    logic [4:0]  M_ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] Dout;
    logic [31:0] EPCout;
    logic        Req;
    logic [31:0] handler_pc;

    modport master (
        output A1, A2, Din, we, M_pc, M_bd, M_ExcCode, HWInt, EXLClr,
        input  Dout, EPCout, Req, handler_pc
    );

    modport slave (
        input  A1, A2, Din, we, M_pc, M_bd, M_ExcCode, HWInt, EXLClr,
        output Dout, EPCout, Req, handler_pc
    );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers, interrupt/exception request logic and eret target.
// Request is combinational so the pipeline can flush in the same cycle the event is seen.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VAL     = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT
) (
    input logic        clk,
    input logic        reset,
    cp0_unit_if.slave  bus
);

    logic [5:0]  sr_im_q, sr_im_d;
    exl_state_e  sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic in_handler;
    logic int_req;
    logic exc_req;
    logic req;
    logic mtc0_en;

    assign in_handler = (sr_exl_q == StHandler);
    assign int_req    = (|(bus.HWInt & sr_im_q)) & sr_ie_q & ~in_handler;
    assign exc_req    = (bus.M_ExcCode != EXC_NONE) & ~in_handler;
    // While reset is held the exception input may be garbage; never request then.
    assign req        = reset & (int_req | exc_req);
    assign mtc0_en    = bus.we & ~req;

    always_comb begin
        sr_im_d  = sr_im_q;
        sr_exl_d = sr_exl_q;
        sr_ie_d  = sr_ie_q;
        if (req) begin
            sr_exl_d = StHandler;
        end else begin
            if (bus.EXLClr) begin
                sr_exl_d = StNormal;
            end
            // An mtc0 to SR overrides a same-edge eret for determinism.
            if (mtc0_en && bus.A2 == CP0_SR) begin
                sr_im_d  = bus.Din[SR_IM_MSB:SR_IM_LSB];
                sr_exl_d = exl_state_e'(bus.Din[SR_EXL_BIT]);
                sr_ie_d  = bus.Din[SR_IE_BIT];
            end
        end
    end

    always_comb begin
        cause_ip_d  = bus.HWInt;
        cause_bd_d  = cause_bd_q;
        cause_exc_d = cause_exc_q;
        if (req) begin
            cause_bd_d  = bus.M_bd;
            cause_exc_d = int_req ? EXC_INT : bus.M_ExcCode;
        end
    end

    always_comb begin
        epc_d = epc_q;
        if (req) begin
            epc_d = bus.M_bd ? (bus.M_pc - 32'd4) : bus.M_pc;
        end else if (mtc0_en && bus.A2 == CP0_EPC) begin
            epc_d = bus.Din & 32'hFFFF_FFFC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q  <= '0;
            sr_exl_q <= StNormal;
            sr_ie_q  <= 1'b0;
        end else begin
            sr_im_q  <= sr_im_d;
            sr_exl_q <= sr_exl_d;
            sr_ie_q  <= sr_ie_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
        end else begin
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

    always_comb begin
        case (bus.A1)
            CP0_SR:    bus.Dout = pack_sr(sr_im_q, in_handler, sr_ie_q);
            CP0_CAUSE: bus.Dout = pack_cause(cause_bd_q, cause_ip_q, cause_exc_q);
            CP0_EPC:   bus.Dout = epc_q;
            CP0_PRID:  bus.Dout = PRID_VAL;
            default:   bus.Dout = '0;
        endcase
    end

    assign bus.EPCout     = epc_q;
    assign bus.Req        = req;
    assign bus.handler_pc = req ? HANDLER_ADDR : 32'h0;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a word-level model of the CP0 registers.
module tb_cp0_unit;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: architectural register words as software would read them.
    logic [31:0] m_sr, m_cause, m_epc;

    function automatic logic m_int();
        return reset && ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return reset && !m_sr[1] && (m_int() || bus.M_ExcCode != 5'd0);
    endfunction

    function automatic logic [31:0] m_next_sr();
        logic [31:0] s;
        s = m_sr;
        if (m_req()) s[1] = 1'b1;
        else begin
            if (bus.EXLClr) s[1] = 1'b0;
            if (bus.we && bus.A2 == 5'd12) s = bus.Din & 32'h0000_FC03;
        end
        return s;
    endfunction

    function automatic logic [31:0] m_next_cause();
        logic [31:0] c;
        c = m_cause;
        c[15:10] = bus.HWInt;
        if (m_req()) begin
            c[31]  = bus.M_bd;
            c[6:2] = m_int() ? 5'd0 : bus.M_ExcCode;
        end
        return c;
    endfunction

    function automatic logic [31:0] m_next_epc();
        if (m_req()) return bus.M_bd ? bus.M_pc - 32'd4 : bus.M_pc;
        if (bus.we && bus.A2 == 5'd14) return {bus.Din[31:2], 2'b00};
        return m_epc;
    endfunction

    function automatic logic [31:0] m_dout();
        case (bus.A1)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_7F7F;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sr    <= '0;
            m_cause <= '0;
            m_epc   <= '0;
        end else begin
            m_sr    <= m_next_sr();
            m_cause <= m_next_cause();
            m_epc   <= m_next_epc();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, mid-cycle so inputs and state are settled.
    always @(negedge clk) begin
        chk("req", {31'd0, bus.Req}, {31'd0, m_req()});
        chk("handler_pc", bus.handler_pc, m_req() ? 32'h0000_4180 : 32'h0);
        chk("epcout", bus.EPCout, m_epc);
        chk("dout", bus.Dout, m_dout());
    end

    task automatic idle();
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.Din = 32'h0; bus.we = 1'b0;
        bus.M_pc = 32'h0; bus.M_bd = 1'b0; bus.M_ExcCode = 5'd0;
        bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string name, input logic [31:0] exp);
        bus.A1 = a;
        #1;
        chk(name, bus.Dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        idle();
        bus.HWInt = 6'h3F;
        bus.M_ExcCode = 5'd12;
        #2;
        chk("t1_req_in_reset", {31'd0, bus.Req}, 32'd0);
        repeat (2) @(negedge clk);
        tick();
        reset = 1'b1;
        idle();
        rd(5'd12, "t1_sr", 32'h0);
        rd(5'd13, "t1_cause", 32'h0);
        rd(5'd14, "t1_epc", 32'h0);
        rd(5'd15, "t1_prid", 32'h0000_7F7F);

        bus.we = 1'b1; bus.A2 = 5'd12; bus.Din = 32'h0000_0401;
        tick();
        idle();
        bus.HWInt = 6'b000001; bus.M_pc = 32'h3010;
        #1;
        chk("t2_req", {31'd0, bus.Req}, 32'd1);
        chk("t2_handler_pc", bus.handler_pc, 32'h0000_4180);
        tick();
        idle();
        rd(5'd13, "t2_cause", 32'h0000_0400);
        rd(5'd14, "t2_epc", 32'h0000_3010);
        rd(5'd12, "t2_sr", 32'h0000_0403);
        bus.EXLClr = 1'b1;
        tick();
        idle();
        rd(5'd12, "t2_eret_sr", 32'h0000_0401);

        bus.M_ExcCode = 5'd4; bus.M_bd = 1'b1; bus.M_pc = 32'h3008;
        #1;
        chk("t3_req", {31'd0, bus.Req}, 32'd1);
        tick();
        idle();
        rd(5'd14, "t3_epc", 32'h0000_3004);
        rd(5'd13, "t3_cause", 32'h8000_0010);

        bus.M_ExcCode = 5'd12; bus.M_pc = 32'h5000;
        #1;
        chk("t4_req_masked", {31'd0, bus.Req}, 32'd0);
        tick();
        idle();
        rd(5'd14, "t4_epc", 32'h0000_3004);
        rd(5'd13, "t4_cause", 32'h8000_0010);
        bus.EXLClr = 1'b1;
        tick();
        idle();
        rd(5'd12, "t4_sr", 32'h0000_0401);

        bus.we = 1'b1; bus.A2 = 5'd14; bus.Din = 32'h0000_3007;
        bus.M_ExcCode = 5'd8; bus.M_pc = 32'h3020;
        #1;
        chk("t5_req", {31'd0, bus.Req}, 32'd1);
        tick();
        idle();
        rd(5'd14, "t5_epc_exc", 32'h0000_3020);
        bus.we = 1'b1; bus.A2 = 5'd14; bus.Din = 32'h0000_3007;
        #1;
        chk("t5_epc_rdw", bus.EPCout, 32'h0000_3020);
        tick();
        idle();
        #1;
        chk("t5_epc_written", bus.EPCout, 32'h0000_3004);

        bus.EXLClr = 1'b1;
        tick();
        idle();
        bus.HWInt = 6'b000001; bus.M_ExcCode = 5'd10; bus.M_pc = 32'h3100;
        tick();
        idle();
        rd(5'd13, "t6_cause", 32'h0000_0400);

        bus.M_ExcCode = 5'd12;
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mid_req", {31'd0, bus.Req}, 32'd0);
        rd(5'd12, "reset_mid_sr", 32'h0);
        tick();
        reset = 1'b1;
        idle();

        for (int i = 0; i < 600; i++) begin
            tick();
            if ($urandom_range(0, 99) == 0) reset = 1'b0;
            else reset = 1'b1;
            bus.A1 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            bus.A2 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            bus.Din = $urandom;
            if ($urandom_range(0, 1) == 1) bus.Din[0] = 1'b1;
            bus.we = ($urandom_range(0, 9) < 3);
            bus.M_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            bus.M_bd = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0: bus.M_ExcCode = 5'd4;
                1: bus.M_ExcCode = 5'd12;
                2: bus.M_ExcCode = 5'($urandom);
                default: bus.M_ExcCode = 5'd0;
            endcase
            bus.HWInt = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            bus.EXLClr = ($urandom_range(0, 9) < 2);
        end
        tick();
        reset = 1'b1;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
